// File: rtl/fpu_norm_round.sv
// Post-add normalizer/rounder: renormalizes the WIDTH+1-bit adder magnitude one bit
// per cycle, rounds nearest-even on a carry-out and holds the result on a valid/ready port.
module fpu_norm_round #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned EXP_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic             sum_sign,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mant_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             sign_out,
  output logic             flag_zero,
  output logic             flag_uflow,
  output logic             flag_oflow
);

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [WIDTH:0]   M_ONE    = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   m;
  logic [EXP_W-1:0] e;
  logic             s;
  logic             rbit;

  logic [EXP_W-1:0] e_inc;
  logic [WIDTH:0]   m_inc;

  assign e_inc = e + EXP_ONE;
  assign m_inc = m + M_ONE;

  // Handshake flags and result fields are straight decodes of registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mant_out  = m[WIDTH-1:0];
  assign exp_out   = e;
  assign sign_out  = s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m          <= '0;
      e          <= '0;
      s          <= 1'b0;
      rbit       <= 1'b0;
      flag_zero  <= 1'b0;
      flag_uflow <= 1'b0;
      flag_oflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m          <= sum;
            e          <= exp_in;
            s          <= sum_sign;
            rbit       <= 1'b0;
            flag_zero  <= 1'b0;
            flag_uflow <= 1'b0;
            flag_oflow <= 1'b0;
            state      <= NORM;
          end
        end

        // Priority chain: special exponent, zero, carry-out, normalized, exponent floor, shift.
        NORM: begin
          if (e == EXP_ONES) begin
            state <= DONE;
          end else if (m == '0) begin
            e         <= '0;
            s         <= 1'b0;
            flag_zero <= 1'b1;
            state     <= DONE;
          end else if (m[WIDTH]) begin
            rbit <= m[0];
            e    <= e_inc;
            if (e_inc == EXP_ONES) begin
              flag_oflow <= 1'b1;
              m          <= '0;
              state      <= DONE;
            end else begin
              m     <= m >> 1;
              state <= ROUND;
            end
          end else if (m[WIDTH-1]) begin
            if (e == '0) begin
              e <= EXP_ONE;
            end
            state <= DONE;
          end else if (e <= EXP_ONE) begin
            e          <= '0;
            flag_uflow <= 1'b1;
            state      <= DONE;
          end else begin
            m <= m << 1;
            e <= e - EXP_ONE;
          end
        end

        // Round-up may carry into m[WIDTH]; renormalize once and recheck overflow.
        ROUND: begin
          if (rbit && m[0]) begin
            if (m_inc[WIDTH]) begin
              e <= e_inc;
              if (e_inc == EXP_ONES) begin
                flag_oflow <= 1'b1;
                m          <= '0;
              end else begin
                m <= m_inc >> 1;
              end
            end else begin
              m <= m_inc;
            end
          end
          state <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_norm_round.sv
// Scoreboard bench for fpu_norm_round (WIDTH=8, EXP_W=5): driver pushes model results,
// monitor pops on out_valid and checks fields, latency, hold stability and in_ready.
module tb_fpu_norm_round;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W:0]    sum_i = '0;
  logic          sign_i = 1'b0;
  logic [EW-1:0] exp_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  mant_out;
  logic [EW-1:0] exp_out;
  logic          sign_out;
  logic          flag_zero;
  logic          flag_uflow;
  logic          flag_oflow;

  fpu_norm_round #(.WIDTH(W), .EXP_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum_i), .sum_sign(sign_i), .exp_in(exp_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .exp_out(exp_out), .sign_out(sign_out),
    .flag_zero(flag_zero), .flag_uflow(flag_uflow), .flag_oflow(flag_oflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  mant;
    logic [EW-1:0] ex;
    logic          sign;
    logic          z;
    logic          u;
    logic          o;
    int            lat;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   outstanding = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   stall_req = 0;

  logic [16:0] fields;
  assign fields = {mant_out, exp_out, sign_out, flag_zero, flag_uflow, flag_oflow};

  task automatic chk(input bit ok, input string name, input string act, input string req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  // Closed-form reference: leading-zero count bounded by the exponent floor.
  function automatic exp_t model(input int sum, input int e, input bit sgn);
    exp_t r;
    int m, ex, msb, lz, k;
    r.mant = '0; r.ex = '0; r.sign = sgn; r.z = 1'b0; r.u = 1'b0; r.o = 1'b0;
    r.lat = 2; r.acc = 0;
    if (e == 31) begin
      r.mant = 8'(sum & 255);
      r.ex   = 5'(31);
    end else if (sum == 0) begin
      r.sign = 1'b0;
      r.z    = 1'b1;
    end else if (sum >= 256) begin
      m  = sum / 2;
      ex = e + 1;
      if (ex == 31) begin
        r.o = 1'b1; m = 0;
      end else begin
        r.lat = 3;
        if ((sum % 2 == 1) && (m % 2 == 1)) m = m + 1;
        if (m == 256) begin
          m  = 128;
          ex = ex + 1;
          if (ex == 31) begin r.o = 1'b1; m = 0; end
        end
      end
      r.mant = 8'(m);
      r.ex   = 5'(ex);
    end else begin
      msb = 0;
      for (int i = 0; i < 8; i++) if (((sum >> i) & 1) == 1) msb = i;
      lz = 7 - msb;
      k  = (e >= 1) ? ((lz < e - 1) ? lz : e - 1) : 0;
      r.mant = 8'((sum << k) & 255);
      r.lat  = 2 + k;
      if (k == lz) begin
        ex   = e - lz;
        r.ex = 5'((ex == 0) ? 1 : ex);
      end else begin
        r.ex = '0;
        r.u  = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (!ok) chk(1'b0, "in_ready_timeout", "in_ready=0", "in_ready=1 within 100 cycles");
  endtask

  task automatic send(input int sum, input int e, input bit sgn);
    bit   ok;
    exp_t x;
    wait_ready(ok);
    if (!ok) return;
    sum_i = 9'(sum); exp_i = 5'(e); sign_i = sgn; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    x = model(sum, e, sgn);
    x.acc = cyc;
    q.push_back(x);
    outstanding++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({fields, out_valid} == 18'h0, {tag, "_outs"},
        $sformatf("%h", {fields, out_valid}), "0");
    chk(in_ready == 1'b1, {tag, "_in_ready"}, $sformatf("%b", in_ready), "1");
  endtask

  // Monitor: compare on first sight of out_valid, then check the held result each stall cycle.
  initial begin
    bit          holding = 1'b0;
    bit          directed = 1'b0;
    logic [16:0] snap = '0;
    int          held = 0;
    int          stall_left = 0;
    exp_t        x;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk(in_ready == (outstanding == 0), "in_ready",
            $sformatf("%b", in_ready), $sformatf("%b", outstanding == 0));
        if (out_valid) begin
          if (!holding) begin
            if (q.size() == 0) begin
              chk(1'b0, "spurious_out", $sformatf("%h", fields), "no output");
            end else begin
              x = q.pop_front();
              chk(fields == {x.mant, x.ex, x.sign, x.z, x.u, x.o}, "result",
                  $sformatf("m=%h e=%0d s=%b z%b u%b o%b", mant_out, exp_out, sign_out,
                            flag_zero, flag_uflow, flag_oflow),
                  $sformatf("m=%h e=%0d s=%b z%b u%b o%b", x.mant, x.ex, x.sign,
                            x.z, x.u, x.o));
              chk(cyc + 1 - x.acc == x.lat, "latency",
                  $sformatf("%0d", cyc + 1 - x.acc), $sformatf("%0d", x.lat));
            end
            holding    = 1'b1;
            snap       = fields;
            held       = 0;
            stall_left = stall_req;
            directed   = (stall_req > 0);
            stall_req  = 0;
          end else begin
            chk(fields == snap, "hold_stable", $sformatf("%h", fields), $sformatf("%h", snap));
          end
          held++;
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = directed ? 1'b1 : 1'($urandom_range(0, 2) != 0);
          end
        end else begin
          if (holding) chk(1'b0, "valid_dropped", "out_valid=0", "out_valid=1");
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk);
      if (holding && out_ready) begin
        if (directed) chk(held == 4, "stall_accept_cycle", $sformatf("%0d", held), "4");
        holding  = 1'b0;
        directed = 1'b0;
        outstanding--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int s, e, kind;
    #3 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    send(9'h0C0, 10, 1'b1);
    send(9'h003, 10, 1'b0);
    send(9'h183, 10, 1'b0);
    send(9'h1FF, 10, 1'b0);
    send(9'h001, 3, 1'b0);
    send(9'h000, 7, 1'b1);
    send(9'h100, 30, 1'b0);
    send(9'h080, 0, 1'b0);
    send(9'h155, 31, 1'b1);
    send(9'h1FF, 29, 1'b0);
    send(9'h040, 1, 1'b1);
    wait_ready(ok);
    stall_req = 3;
    send(9'h0A5, 12, 1'b1);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      s = 0;
      else if (kind <= 3) s = 256 + $urandom_range(0, 255);
      else if (kind <= 6) s = $urandom_range(1, 255);
      else                s = (1 << $urandom_range(0, 7)) | $urandom_range(0, 3);
      kind = $urandom_range(0, 7);
      case (kind)
        0: e = 0;
        1: e = 1;
        2: e = 2;
        3: e = 30;
        4: e = 31;
        default: e = $urandom_range(0, 31);
      endcase
      send(s, e, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a multi-cycle normalization, then a clean op.
    wait_ready(ok);
    if (ok) begin
      sum_i = 9'h003; exp_i = 5'(10); sign_i = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      outstanding++;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      outstanding = 0;
      #1 check_reset_outputs("mid_norm_reset");
      @(negedge clk);
      #2 rst_n = 1'b1;
    end
    send(9'h0C0, 10, 1'b1);

    begin
      int t = 0;
      while (outstanding != 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    chk(outstanding == 0 && q.size() == 0, "drain",
        $sformatf("outstanding=%0d queued=%0d", outstanding, q.size()), "0 and 0");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
